circle_engine: RTL

Parametrised midpoint-circle raster engine driving the VGA adapter pixel port. It succeeds the fixed 160x120 outline-only circle drawer. Screen size, coordinate widths and colour width are parameters, and the block adds a filled-disc mode and per-pixel screen clipping with deterministic cycle counts. It sits between the top-level control FSM (start/done handshake) and the `vga_adapter` instance.

---
 rtl/circle_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser feeding the VGA adapter pixel port: outline or
// filled disc, clipped per pixel to the screen, one pixel slot per cycle.
module circle_engine #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned R_W      = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                fill,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int unsigned CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int unsigned OW = R_W + 2;
  localparam int unsigned KW = R_W + 3;

  localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    OUTLINE = 3'd2,
    SPAN    = 3'd3,
    STEP    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_fill;
  logic signed [CW-1:0]  r_cx;
  logic signed [CW-1:0]  r_cy;
  logic [COLOUR_W-1:0]   r_col;
  logic signed [OW-1:0]  r_ox;
  logic signed [OW-1:0]  r_oy;
  logic signed [OW-1:0]  r_dx;
  logic signed [KW-1:0]  r_crit;
  logic [2:0]            r_oct;
  logic [1:0]            r_span;

  logic signed [OW-1:0]  w_offx;
  logic signed [OW-1:0]  w_offy;
  logic signed [CW-1:0]  w_px;
  logic signed [CW-1:0]  w_py;
  logic                  w_on_screen;
  logic signed [OW-1:0]  w_oy_n;
  logic signed [OW-1:0]  w_ox_n;
  logic signed [KW-1:0]  w_crit_n;
  logic                  w_crit_le0;
  logic                  w_cont;
  logic                  w_span_end;
  logic                  w_step;
  logic                  w_pix;

  // Pixel offset for the current slot: octant mirror or span position.
  always_comb begin
    w_offx = '0;
    w_offy = '0;
    if (r_state == OUTLINE) begin
      unique case (r_oct)
        3'd0: begin w_offx =  r_ox; w_offy =  r_oy; end
        3'd1: begin w_offx =  r_oy; w_offy =  r_ox; end
        3'd2: begin w_offx = -r_ox; w_offy =  r_oy; end
        3'd3: begin w_offx = -r_oy; w_offy =  r_ox; end
        3'd4: begin w_offx = -r_ox; w_offy = -r_oy; end
        3'd5: begin w_offx = -r_oy; w_offy = -r_ox; end
        3'd6: begin w_offx =  r_ox; w_offy = -r_oy; end
        default: begin w_offx =  r_oy; w_offy = -r_ox; end
      endcase
    end else begin
      w_offx = r_dx;
      unique case (r_span)
        2'd0:    w_offy =  r_oy;
        2'd1:    w_offy = -r_oy;
        2'd2:    w_offy =  r_ox;
        default: w_offy = -r_ox;
      endcase
    end
  end

  assign w_px        = r_cx + CW'(w_offx);
  assign w_py        = r_cy + CW'(w_offy);
  assign w_on_screen = !w_px[CW-1] && (w_px < SW_S) && !w_py[CW-1] && (w_py < SH_S);

  // Spans 0/1 run over +-ox, spans 2/3 over +-oy.
  assign w_span_end  = (r_dx == (r_span[1] ? r_oy : r_ox));

  // Midpoint decision, evaluated with the already-advanced oy/ox.
  assign w_crit_le0  = r_crit[KW-1] || (r_crit == '0);

  always_comb begin
    w_oy_n   = r_oy + OW'(1);
    w_ox_n   = r_ox;
    w_crit_n = r_crit + (KW'(w_oy_n) <<< 1) + KW'(1);
    if (!w_crit_le0) begin
      w_ox_n   = r_ox - OW'(1);
      w_crit_n = r_crit + ((KW'(w_oy_n) - KW'(w_ox_n)) <<< 1) + KW'(1);
    end
  end

  assign w_cont = (w_oy_n <= w_ox_n);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; STEP is folded into the last pixel slot of each iteration.
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    w_pix  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = INIT;
      end
      INIT: begin
        w_next = r_fill ? SPAN : OUTLINE;
      end
      OUTLINE: begin
        w_pix = 1'b1;
        if (r_oct == 3'd7) begin
          w_step = 1'b1;
          w_next = w_cont ? OUTLINE : DONE;
        end
      end
      SPAN: begin
        w_pix = 1'b1;
        if (w_span_end && (r_span == 2'd3)) begin
          w_step = 1'b1;
          w_next = w_cont ? SPAN : DONE;
        end
      end
      DONE: begin
        if (!start) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath and registered pixel-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      r_fill     <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_col      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_dx       <= '0;
      r_crit     <= '0;
      r_oct      <= '0;
      r_span     <= '0;
    end else begin
      done       <= (r_state == DONE);
      vga_plot   <= w_pix && w_on_screen;
      vga_x      <= X_W'(w_px);
      vga_y      <= Y_W'(w_py);
      vga_colour <= r_col;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_fill <= fill;
            r_cx   <= CW'(centre_x);
            r_cy   <= CW'(centre_y);
            r_col  <= colour;
            r_ox   <= OW'(radius);
          end
        end
        INIT: begin
          r_oy   <= '0;
          r_crit <= KW'(1) - KW'(r_ox);
          r_dx   <= -r_ox;
          r_oct  <= '0;
          r_span <= '0;
        end
        OUTLINE: begin
          r_oct <= r_oct + 3'd1;
          if (w_step) begin
            r_ox   <= w_ox_n;
            r_oy   <= w_oy_n;
            r_crit <= w_crit_n;
          end
        end
        SPAN: begin
          if (w_span_end) begin
            r_span <= r_span + 2'd1;
            unique case (r_span)
              2'd0:       r_dx <= -r_ox;
              2'd1, 2'd2: r_dx <= -r_oy;
              default:    r_dx <= -w_ox_n;
            endcase
          end else begin
            r_dx <= r_dx + OW'(1);
          end
          if (w_step) begin
            r_ox   <= w_ox_n;
            r_oy   <= w_oy_n;
            r_crit <= w_crit_n;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
